wb_regfile: RTL and testbench

- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result (memory data or ALU result) and commits it to a 32-entry general register file.
- Register file has two asynchronous read ports, used by the decode stage.
- Also keeps a committed-writeback counter for debug and performance bring-up.

---
 rtl/wb_regfile_if.sv | 26 ++
 rtl/wb_regfile.sv | 38 +++
 tb/tb_wb_regfile.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB writeback inputs and decode read ports of the register file
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              regWriteW;
  logic              MemtoRegW;
  logic [DATA_W-1:0] readDataW;
  logic [DATA_W-1:0] AluOutW;
  logic [ADDR_W-1:0] WriteRegW;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] ResultW;
  logic [CNT_W-1:0]  wbCount;
  modport master (
    output regWriteW, MemtoRegW, readDataW, AluOutW, WriteRegW, A1, A2,
    input  RD1, RD2, ResultW, wbCount
  );
  modport slave (
    input  regWriteW, MemtoRegW, readDataW, AluOutW, WriteRegW, A1, A2,
    output RD1, RD2, ResultW, wbCount
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback result mux, 32-entry register file with two async read ports, commit counter.
// Define WB_REGFILE_BYPASS_EN for write-first read bypass of the committing value.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         clr,
  wb_regfile_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [CNT_W-1:0]  r_cnt;
  logic              w_commit;
  logic [DATA_W-1:0] w_result;
  assign w_result = bus.MemtoRegW ? bus.readDataW : bus.AluOutW;
  assign w_commit = bus.regWriteW && (bus.WriteRegW != '0) && !clr;
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_cnt <= '0;
    end else if (w_commit) begin
      r_regs[bus.WriteRegW] <= w_result;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`ifdef WB_REGFILE_BYPASS_EN
  // w_commit already excludes index 0 and clr, so bypass never leaks into r0
  assign bus.RD1 = (bus.A1 == '0) ? '0 : (w_commit && bus.A1 == bus.WriteRegW) ? w_result : r_regs[bus.A1];
  assign bus.RD2 = (bus.A2 == '0) ? '0 : (w_commit && bus.A2 == bus.WriteRegW) ? w_result : r_regs[bus.A2];
`else
  assign bus.RD1 = (bus.A1 == '0) ? '0 : r_regs[bus.A1];
  assign bus.RD2 = (bus.A2 == '0) ? '0 : r_regs[bus.A2];
`endif
  assign bus.ResultW = w_result;
  assign bus.wbCount = r_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors with literal checks plus a per-cycle reference-model compare.
module tb_wb_regfile;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  bit          m_valid = 1'b0;
  function automatic logic [31:0] m_result();
    return bus.MemtoRegW ? bus.readDataW : bus.AluOutW;
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && !clr && bus.regWriteW && a == bus.WriteRegW) return m_result();
    return m_regs[a];
  endfunction
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_cnt   <= 32'd0;
      m_valid <= 1'b1;
    end else if (bus.regWriteW && bus.WriteRegW != 5'd0) begin
      m_regs[bus.WriteRegW] <= m_result();
      m_cnt <= m_cnt + 32'd1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model ResultW", bus.ResultW, m_result());
      chk("model RD1", bus.RD1, m_read(bus.A1));
      chk("model RD2", bus.RD2, m_read(bus.A2));
      chk("model wbCount", bus.wbCount, m_cnt);
    end
  end
  task automatic cyc(input logic c, input logic rw, input logic m, input logic [31:0] rd,
                     input logic [31:0] alu, input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    clr = c;
    bus.regWriteW = rw;
    bus.MemtoRegW = m;
    bus.readDataW = rd;
    bus.AluOutW = alu;
    bus.WriteRegW = wr;
    bus.A1 = a1;
    bus.A2 = a2;
    @(negedge clk);
  endtask
  initial begin
    bus.regWriteW = 1'b0;
    bus.MemtoRegW = 1'b0;
    bus.readDataW = '0;
    bus.AluOutW = '0;
    bus.WriteRegW = '0;
    bus.A1 = '0;
    bus.A2 = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 5, 9);
    chk("reset RD1", bus.RD1, 32'h0);
    chk("reset wbCount", bus.wbCount, 32'd0);
    cyc(0, 1, 0, 32'h0, 32'h1234, 5, 0, 0);
    chk("preload ResultW", bus.ResultW, 32'h1234);
    cyc(0, 0, 0, 0, 0, 0, 5, 0);
    chk("preload RD1", bus.RD1, 32'h1234);
    chk("preload wbCount", bus.wbCount, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 5, 0);
    chk("clr RD1", bus.RD1, 32'h0);
    chk("clr wbCount", bus.wbCount, 32'd0);
    cyc(0, 1, 0, 32'h11111111, 32'hDEADBEEF, 8, 0, 0);
    chk("alu ResultW", bus.ResultW, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 8);
    chk("alu RD2", bus.RD2, 32'hDEADBEEF);
    chk("alu wbCount", bus.wbCount, 32'd1);
    cyc(0, 1, 1, 32'hCAFEF00D, 32'h0, 31, 0, 0);
    chk("mem ResultW", bus.ResultW, 32'hCAFEF00D);
    cyc(0, 0, 0, 0, 0, 0, 31, 8);
    chk("mem RD1", bus.RD1, 32'hCAFEF00D);
    chk("same-index RD2", bus.RD2, 32'hDEADBEEF);
    chk("mem wbCount", bus.wbCount, 32'd2);
    cyc(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
    chk("r0 write RD1", bus.RD1, 32'h0);
    chk("r0 write RD2", bus.RD2, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0 after RD1", bus.RD1, 32'h0);
    chk("r0 after wbCount", bus.wbCount, 32'd2);
    cyc(0, 1, 0, 0, 32'h5, 3, 0, 0);
    cyc(0, 1, 0, 0, 32'h7, 3, 3, 3);
    chk("same-cycle RD1", bus.RD1, BYP ? 32'h7 : 32'h5);
    cyc(0, 0, 0, 0, 0, 0, 3, 0);
    chk("next-cycle RD1", bus.RD1, 32'h7);
    chk("rw wbCount", bus.wbCount, 32'd4);
    cyc(1, 1, 0, 0, 32'h99, 4, 4, 0);
    chk("clr-prio no bypass", bus.RD1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 4, 8);
    chk("clr-prio r4", bus.RD1, 32'h0);
    chk("clr-prio r8", bus.RD2, 32'h0);
    chk("clr-prio wbCount", bus.wbCount, 32'd0);
    cyc(0, 0, 1, 32'hAAAA5555, 32'h12345678, 9, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 9, 9);
    chk("no-wen RD1", bus.RD1, 32'h0);
    chk("no-wen wbCount", bus.wbCount, 32'd0);
    cyc(0, 1, 0, 0, 32'h42, 6, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 6, 6);
    chk("first-after-clr wbCount", bus.wbCount, 32'd1);
    for (int i = 0; i < 60; i++)
      cyc(0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
